// File: rtl/gsim_banded_solver.sv
// Gauss-Seidel solver for a symmetric banded Toeplitz system (20, -13, 6, -1).
// Loads b as a word stream, sweeps in place on x[], then streams x out.
module gsim_banded_solver #(
    parameter int N    = 16,
    parameter int B_W  = 16,
    parameter int X_W  = 32,
    parameter int FRAC = 16,
    parameter int ITER = 128,
    parameter int TOL  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_en,
    input  logic signed [B_W-1:0]         b_in,
    output logic                          busy,
    output logic                          out_valid,
    output logic signed [X_W-1:0]         x_out,
    output logic [$clog2(ITER+1)-1:0]     iter_cnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(ITER + 1);
    localparam int SW = ((X_W > B_W + FRAC) ? X_W : B_W + FRAC) + 7;

    localparam logic [IW-1:0]        LAST   = IW'(N - 1);
    localparam logic [CW-1:0]        ITER_V = CW'(ITER);
    localparam logic [X_W:0]         TOL_V  = (X_W + 1)'(TOL);
    localparam logic signed [SW-1:0] C6     = SW'(6);
    localparam logic signed [SW-1:0] C13    = SW'(13);
    localparam logic signed [SW-1:0] C20    = SW'(20);
    localparam logic signed [SW-1:0] XMAX   = {{(SW - X_W + 1){1'b0}}, {(X_W - 1){1'b1}}};
    localparam logic signed [SW-1:0] XMIN   = {{(SW - X_W + 1){1'b1}}, {(X_W - 1){1'b0}}};

    typedef enum logic [1:0] {LOAD, COMP, OUT} state_t;

    state_t                 state, state_next;
    logic [IW-1:0]          idx;
    logic [CW-1:0]          sweep;
    logic [X_W:0]           maxdelta;
    logic signed [B_W-1:0]  b_mem [N];
    logic signed [X_W-1:0]  x_mem [N];

    logic signed [X_W-1:0]  nb [7];
    logic signed [SW-1:0]   s_full, q_trunc, r_trunc, q_floor;
    logic signed [X_W-1:0]  x_old, x_new;
    logic signed [X_W:0]    diff;
    logic [X_W:0]           abs_delta, md_new;
    logic [CW-1:0]          sweep_inc;
    logic                   last_i, done;

    // Neighbour taps x[i-3..i+3]; taps falling outside the vector read as zero.
    always_comb begin
        for (int k = 0; k < 7; k++) begin
            nb[k] = '0;
            if ((int'(idx) + k - 3 >= 0) && (int'(idx) + k - 3 < N))
                nb[k] = x_mem[IW'(int'(idx) + k - 3)];
        end
    end

    // Full-precision row sum, floor division by the diagonal, then saturation.
    always_comb begin
        x_old   = x_mem[idx];
        s_full  = (SW'(b_mem[idx]) <<< FRAC)
                + C13 * (SW'(nb[2]) + SW'(nb[4]))
                - C6  * (SW'(nb[1]) + SW'(nb[5]))
                + (SW'(nb[0]) + SW'(nb[6]));
        q_trunc = s_full / C20;
        r_trunc = s_full % C20;
        q_floor = (s_full < 0 && r_trunc != 0) ? q_trunc - SW'(1) : q_trunc;
        if (q_floor > XMAX)
            x_new = XMAX[X_W-1:0];
        else if (q_floor < XMIN)
            x_new = XMIN[X_W-1:0];
        else
            x_new = q_floor[X_W-1:0];
        diff      = {x_new[X_W-1], x_new} - {x_old[X_W-1], x_old};
        abs_delta = (diff < 0) ? $unsigned(-diff) : $unsigned(diff);
        md_new    = (abs_delta > maxdelta) ? abs_delta : maxdelta;
        last_i    = (idx == LAST);
        sweep_inc = sweep + 1'b1;
        done      = last_i && ((sweep_inc == ITER_V) || (TOL != 0 && md_new <= TOL_V));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= LOAD;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (in_en && last_i) state_next = COMP;
            COMP:    if (done)            state_next = OUT;
            OUT:     if (last_i)          state_next = LOAD;
            default:                      state_next = LOAD;
        endcase
    end

    always_comb begin
        busy      = (state != LOAD);
        out_valid = (state == OUT);
        x_out     = out_valid ? x_mem[idx] : '0;
        iter_cnt  = out_valid ? sweep : '0;
    end

    // idx walks b[] during load, the row being updated in COMP, the output word in OUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx      <= '0;
            sweep    <= '0;
            maxdelta <= '0;
            for (int k = 0; k < N; k++) begin
                b_mem[k] <= '0;
                x_mem[k] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_en) begin
                        b_mem[idx] <= b_in;
                        if (last_i) begin
                            idx      <= '0;
                            sweep    <= '0;
                            maxdelta <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                COMP: begin
                    x_mem[idx] <= x_new;
                    if (last_i) begin
                        idx      <= '0;
                        sweep    <= sweep_inc;
                        maxdelta <= done ? md_new : '0;
                    end else begin
                        idx      <= idx + 1'b1;
                        maxdelta <= md_new;
                    end
                end
                OUT: begin
                    if (last_i) begin
                        idx   <= '0;
                        sweep <= '0;
                        for (int k = 0; k < N; k++)
                            x_mem[k] <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: idx <= '0;
            endcase
        end
    end

endmodule
